// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for pipe_stage_skid instances (package pipe_pkg).
// Holds the stage FSM encoding, default widths and control-bundle bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 32;

  // Control bundle layout common to every inter-stage register
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_WREG_LSB = 3;
  localparam int CTRL_WREG_MSB = 7;

  function automatic logic ctrl_is_bubble(input logic [DEF_CTRL_W-1:0] c);
    return (c == {DEF_CTRL_W{1'b0}});
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stage handshake carrying payload and control bundle.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with 2-entry skid buffer, registered in_ready, stall and flush.
// Optional perf counters (stall/bubble) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_stall,
  pipe_stage_skid_if.slave  i_up,
  pipe_stage_skid_if.master o_dn
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = EMPTY;
  localparam logic [1:0] S_BUSY  = BUSY;
  localparam logic [1:0] S_FULL  = FULL;

  logic [1:0]        r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic [1:0]        w_state_nxt;
  logic              w_accept_in;
  logic              w_accept_out;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  assign w_accept_in  = i_up.valid & r_in_ready;
  assign w_accept_out = r_out_valid & o_dn.ready & ~i_stall;

  // Next-state and slot-load decode; flush overrides everything
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept_in) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = S_BUSY;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_BUSY: begin
          if (w_accept_in && w_accept_out) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = S_BUSY;
          end else if (w_accept_in) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_accept_out) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
        S_FULL: begin
          if (w_accept_out) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = S_BUSY;
          end else begin
            w_state_nxt = S_FULL;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // State, handshake flags and storage slots; main ctrl is zeroed whenever the stage empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_data <= {DATA_W{1'b0}};
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_load_main_in) begin
        r_main_data <= i_up.data;
        r_main_ctrl <= i_up.ctrl;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_state_nxt == S_EMPTY) begin
        r_main_ctrl <= {CTRL_W{1'b0}};
      end else begin
        r_main_ctrl <= r_main_ctrl;
      end
      if (w_load_skid) begin
        r_skid_data <= i_up.data;
        r_skid_ctrl <= i_up.ctrl;
      end else begin
        r_skid_ctrl <= r_skid_ctrl;
      end
    end
  end

  assign i_up.ready = r_in_ready;
  assign o_dn.valid = r_out_valid;
  assign o_dn.data  = r_main_data;
  assign o_dn.ctrl  = r_main_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating perf counters; only reset clears them, flush does not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_out_valid && !w_accept_out && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (!r_out_valid && !(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed stimulus pushes expected entries,
// a negedge monitor pops/compares every accepted output and checks hold/bubble rules.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic stall;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(8)) up_if ();
  pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(8)) dn_if ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [3:0]  stall_cnt4;
  logic [3:0]  bubble_cnt4;
  pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(8)) up4_if ();
  pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(8)) dn4_if ();
  assign up4_if.valid = up_if.valid;
  assign up4_if.data  = up_if.data;
  assign up4_if.ctrl  = up_if.ctrl;
  assign dn4_if.ready = dn_if.ready;

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall),
    .i_up(up_if), .o_dn(dn_if), .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
  );
  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall),
    .i_up(up4_if), .o_dn(dn4_if), .o_stall_cnt(stall_cnt4), .o_bubble_cnt(bubble_cnt4)
  );
`else
  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall),
    .i_up(up_if), .o_dn(dn_if)
  );
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: record acceptance just before the edge, then return at posedge+1
  task automatic step(output bit acc);
    @(negedge clk);
    acc = up_if.valid && up_if.ready && !flush && !rst;
    if (acc) q.push_back({up_if.data, up_if.ctrl});
    @(posedge clk);
    #1;
    if (flush) q.delete();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(a);
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] c);
    bit a;
    bit done;
    done = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = d;
    up_if.ctrl  = c;
    for (int k = 0; k < 20 && !done; k++) begin
      step(a);
      done = a;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    up_if.valid = 1'b0;
  endtask

  logic        prev_hold;
  logic [63:0] prev_d;
  logic [7:0]  prev_c;
  exp_t        e;

  // Monitor: scoreboard pop on every downstream transfer, hold and bubble checks
  always @(negedge clk) begin
    if (rst || flush) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(dn_if.valid), 64'd1);
        check("hold_data", dn_if.data, prev_d);
        check("hold_ctrl", 64'(dn_if.ctrl), 64'(prev_c));
      end
      if (!dn_if.valid) check("bubble_ctrl", 64'(ctrl_is_bubble(dn_if.ctrl)), 64'd1);
      if (dn_if.valid && dn_if.ready && !stall) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%0h required=none at %0t", dn_if.data, $time);
        end else begin
          e = q.pop_front();
          check("out_data", dn_if.data, e.d);
          check("out_ctrl", 64'(dn_if.ctrl), 64'(e.c));
        end
      end
      prev_hold <= dn_if.valid && !(dn_if.ready && !stall);
      prev_d    <= dn_if.data;
      prev_c    <= dn_if.ctrl;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    up_if.valid = 1'b0; up_if.data = 64'd0; up_if.ctrl = 8'd0; dn_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(dn_if.valid), 64'd0);
    check("rst_data", dn_if.data, 64'd0);
    check("rst_ctrl", 64'(dn_if.ctrl), 64'd0);
    check("rst_ready", 64'(up_if.ready), 64'd1);
    rst = 1'b0;

    // Streaming, latency 1, one per cycle
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 64'(i);
      up_if.ctrl  = 8'(i) | 8'h80;
      step(a);
      check("stream_acc", 64'(a), 64'd1);
      check("stream_valid", 64'(dn_if.valid), 64'd1);
      check("stream_data", dn_if.data, 64'(i));
    end
    up_if.valid = 1'b0;
    idle(2);
    check("stream_drain", 64'(q.size()), 64'd0);

    // Backpressure into skid
    send(64'hA, 8'h0A);
    dn_if.ready = 1'b0;
    send(64'hB, 8'h0B);
    check("bp_ready", 64'(up_if.ready), 64'd0);
    check("bp_hold", dn_if.data, 64'hA);
    up_if.valid = 1'b1; up_if.data = 64'hC; up_if.ctrl = 8'h0C;
    step(a);
    check("bp_block", 64'(a), 64'd0);
    dn_if.ready = 1'b1;
    send(64'hC, 8'h0C);
    idle(2);
    check("bp_drain", 64'(q.size()), 64'd0);

    // Flush in FULL, then flush in BUSY with in_ready=1
    dn_if.ready = 1'b0;
    send(64'h11, 8'h11);
    send(64'h12, 8'h12);
    check("fl_full", 64'(up_if.ready), 64'd0);
    up_if.valid = 1'b1; up_if.data = 64'hD; up_if.ctrl = 8'hDD; flush = 1'b1;
    step(a);
    flush = 1'b0; up_if.valid = 1'b0;
    check("fl_valid", 64'(dn_if.valid), 64'd0);
    check("fl_ctrl", 64'(dn_if.ctrl), 64'd0);
    check("fl_ready", 64'(up_if.ready), 64'd1);
    dn_if.ready = 1'b1;
    idle(3);
    dn_if.ready = 1'b0;
    send(64'h21, 8'h21);
    up_if.valid = 1'b1; up_if.data = 64'hD; up_if.ctrl = 8'hDD; flush = 1'b1;
    step(a);
    flush = 1'b0; up_if.valid = 1'b0;
    check("fl_busy_valid", 64'(dn_if.valid), 64'd0);
    dn_if.ready = 1'b1;
    idle(2);

    // Stall acts as backpressure for three cycles
    send(64'h31, 8'h31);
    stall = 1'b1;
    send(64'h32, 8'h32);
    check("st_ready", 64'(up_if.ready), 64'd0);
    check("st_hold0", dn_if.data, 64'h31);
    up_if.valid = 1'b1; up_if.data = 64'h33; up_if.ctrl = 8'h33;
    for (int k = 0; k < 2; k++) begin
      step(a);
      check("st_block", 64'(a), 64'd0);
      check("st_hold", dn_if.data, 64'h31);
    end
    stall = 1'b0;
    send(64'h33, 8'h33);
    idle(2);
    check("st_drain", 64'(q.size()), 64'd0);

    // Stall together with flush: flush result
    stall = 1'b1;
    send(64'h41, 8'h41);
    send(64'h42, 8'h42);
    flush = 1'b1;
    step(a);
    flush = 1'b0; stall = 1'b0;
    check("stfl_valid", 64'(dn_if.valid), 64'd0);
    check("stfl_ready", 64'(up_if.ready), 64'd1);
    idle(2);

    // Asynchronous reset while FULL
    dn_if.ready = 1'b0;
    send(64'h51, 8'h51);
    send(64'h52, 8'h52);
    check("mr_full", 64'(up_if.ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid", 64'(dn_if.valid), 64'd0);
    check("mr_ctrl", 64'(dn_if.ctrl), 64'd0);
    check("mr_ready", 64'(up_if.ready), 64'd1);
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    // Counters: 1 bubble, 5 stalls, accept, 2 bubbles
    up_if.valid = 1'b1; up_if.data = 64'h61; up_if.ctrl = 8'h61;
    step(a);
    up_if.valid = 1'b0;
    idle(5);
    dn_if.ready = 1'b1;
    idle(3);
    check("perf_stall", 64'(stall_cnt), 64'd5);
    check("perf_bubble", 64'(bubble_cnt), 64'd3);
    check("perf4_stall", 64'(stall_cnt4), 64'd5);
    dn_if.ready = 1'b0;
    send(64'h62, 8'h62);
    idle(20);
    check("perf_stall_25", 64'(stall_cnt), 64'd25);
    check("perf4_sat", 64'(stall_cnt4), 64'd15);
    check("perf_bubble_4", 64'(bubble_cnt), 64'd4);
    dn_if.ready = 1'b1;
    idle(2);
`endif

    check("final_drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
